mlp_seq_ctrl: RTL
=================

Name: mlp_seq_ctrl

Overview:
- Sequential, area-reduced evaluator for the 16-input / 5-hidden / 1-output ReLU MLP classifier.
- Time-shares one signed 4/12-bit x 8-bit MAC across every neuron of both layers.
- Weights and biases come from external combinational ROM ports, so new trained models need no RTL change.
- Sits between the sensor/feature front end (valid/ready) and the downstream result consumer (valid/ready).

Parameters:
- N_IN, 16, number of input features (4-bit unsigned each)
- N_HID, 5, number of hidden neurons
- IN_W, 4, input feature width
- W_W, 8, weight width (signed)
- B_W, 13, bias width (signed)
- HID_W, 12, hidden activation width (unsigned, post-ReLU)
- OUT_W, 19, output width (unsigned, post-ReLU)
- ACC_W, 21, accumulator width (signed)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  high only in IDLE
- in_data  in  N_IN*IN_W  feature i at bits [4i+3:4i]
- w_addr  out  7  weight ROM address (layer0: n*16+i, 0..79; layer1: 80+j)
- w_data  in  W_W  signed weight, combinational (valid same cycle as w_addr)
- b_sel  out  3  bias select (0..4 hidden, 5 output)
- b_data  in  B_W  signed bias, combinational
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  ReLU output of layer 1
- busy  out  1  high in L0 or L1

Behaviour:
- Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, acc=0, all hidden regs=0, counters n=k=0; w_addr=0 and b_sel=0 (outputs are functions of state/counters).
- States: IDLE, L0, L1, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready the edge latches in_data into the feature register, sets n=0, k=0 and goes to L0.
- L0, one MAC per cycle:
  - w_addr = n*16+k, b_sel = n.
  - prod = signed({0, x[k]}) * w_data.
  - sum = (k==0 ? sign-extended b_data : acc) + prod.
  - k<15: acc <= sum, k++.
  - k==15: take s13 = sum[12:0] as signed; hid[n] <= (s13<0) ? 0 : s13[11:0]; k <= 0; n++.
  - After n==4 completes: go to L1 with j=0.
- L1: w_addr = 80+j, b_sel = 5.
  - prod = signed({0, hid[j]}) * w_data; sum formed as in L0.
  - j==4: take s20 = sum[19:0] as signed; out_data <= (s20<0) ? 0 : s20[18:0]; out_valid <= 1; go to DONE.
- Truncation to 13 bits (L0) and 20 bits (L1) is intentional wrap. The block must be bit-exact with the fully combinational reference model of the same network.
- DONE: out_valid=1 and out_data held stable while out_ready=0. On out_ready: out_valid <= 0, go to IDLE. out_data keeps its last value.
- in_ready=0 in L0, L1 and DONE. in_valid outside IDLE is ignored; input changes then do not disturb the latched features.
- Latency: accepting edge t0, 80 L0 edges (t1..t80), 5 L1 edges (t81..t85). out_valid is high after edge t0+85. Throughput: one inference per 86 cycles minimum (plus one DONE cycle).
- Back-to-back: the earliest next accept is the cycle after the out_ready handshake (IDLE).
- Reset mid-operation aborts the inference with no output; next accept starts clean.
- No handling of out-of-range ROM data is required; any w_data/b_data is legal.

Test Plan:
- ROM loaded with the trained 5x16/1x5 model, in_data=0 held in_valid 1 cycle, out_ready=1 -> hid = {0,0,0,578,0}; out_valid exactly 85 cycles after accept; out_data = 1667+33*578 = 20741.
- Same ROM, all features = 15 -> hid = {0,0,0,113,552}; out_data = 1667+33*113+34*552 = 24164.
- out_ready=0 for 20 cycles after out_valid -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; on out_ready=1, one-cycle handshake then in_ready=1.
- Address trace during one inference -> w_addr steps 0..79 then 80..84, one per cycle; b_sel steps 0 (16 cycles)..4, then 5 (5 cycles).
- rst asserted asynchronously at cycle 40 of L0 -> out_valid=0, out_data=0, busy=0, in_ready=1 immediately; next vector (all 0) gives 20741.
- Randomised 1000 vectors with random ROM contents vs golden combinational model -> bit-exact out_data, including 13/20-bit wrap cases.

Source files
------------

// File: rtl/mlp_seq_ctrl.sv
// mlp_seq_ctrl: sequential evaluator for the 16-input / 5-hidden / 1-output
// ReLU MLP classifier. It uses a single signed multiply-accumulate, shared
// one MAC per cycle across all hidden neurons and then across the output neuron.
// Weights and biases are read from external combinational ROM ports.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   feature-vector handshake (in_ready high only in IDLE)
//   in_data             N_IN packed 4-bit unsigned features, feature i at [4i+3:4i]
//   w_addr/w_data       weight ROM: layer0 at n*N_IN+i, layer1 at N_HID*N_IN+j
//   b_sel/b_data        bias ROM: 0..N_HID-1 for hidden neurons, N_HID for the output
//   out_valid/out_ready result handshake; out_data holds the ReLU output of layer 1
//   busy                high while layer 0 or layer 1 is being evaluated
module mlp_seq_ctrl #(
    parameter int N_IN  = 16,
    parameter int N_HID = 5,
    parameter int IN_W  = 4,
    parameter int W_W   = 8,
    parameter int B_W   = 13,
    parameter int HID_W = 12,
    parameter int OUT_W = 19,
    parameter int ACC_W = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   in_data,
    output logic [6:0]             w_addr,
    input  logic signed [W_W-1:0]  w_data,
    output logic [2:0]             b_sel,
    input  logic signed [B_W-1:0]  b_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   busy
);

    localparam int KW = $clog2(N_IN);
    localparam int NW = $clog2(N_HID);
    localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
    localparam logic [KW-1:0] J_LAST = KW'(N_HID - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_HID - 1);

    typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_t;

    state_t                  state;
    logic [N_IN*IN_W-1:0]    feat;
    logic [HID_W-1:0]        hid [N_HID];
    logic [NW-1:0]           n;
    // k indexes the input feature in L0 and the hidden neuron (j) in L1
    logic [KW-1:0]           k;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] opnd;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] sum;

    // Unsigned activation is zero-extended, so the signed product is exact.
    always_comb begin
        opnd = '0;
        if (state == L1) begin
            opnd[HID_W-1:0] = hid[k[NW-1:0]];
        end else begin
            opnd[IN_W-1:0] = feat[int'(k)*IN_W +: IN_W];
        end
        prod = opnd * ACC_W'(w_data);
        sum  = ((k == '0) ? ACC_W'(b_data) : acc) + prod;
    end

    assign w_addr = (state == L1) ? 7'(N_HID*N_IN + int'(k))
                                  : 7'(int'(n)*N_IN + int'(k));
    assign b_sel  = (state == L1) ? 3'(N_HID) : 3'(n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            feat      <= '0;
            for (int unsigned i = 0; i < N_HID; i++) hid[i] <= '0;
            n         <= '0;
            k         <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat     <= in_data;
                        n        <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= L0;
                    end
                end
                L0: begin
                    if (k == K_LAST) begin
                        // Keep 13 bits of the sum (intentional wrap), then ReLU.
                        hid[n] <= sum[B_W-1] ? '0 : sum[HID_W-1:0];
                        k      <= '0;
                        if (n == N_LAST) begin
                            n     <= '0;
                            state <= L1;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end else begin
                        acc <= sum;
                        k   <= k + 1'b1;
                    end
                end
                L1: begin
                    if (k == J_LAST) begin
                        // Keep 20 bits of the sum (intentional wrap), then ReLU.
                        out_data  <= sum[OUT_W] ? '0 : sum[OUT_W-1:0];
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        k         <= '0;
                        state     <= DONE;
                    end else begin
                        acc <= sum;
                        k   <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
